// File: rtl/known_ch_table.sv
// Known cluster-head table: learns CH adverts (ID, hops, Q), keeps at most the
// heartbeat-granted number of entries, and reports the best CH and hop distance.
module known_ch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_CH     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_KCH,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic [WORD_WIDTH-1:0] fCH_ID,
  input  logic [WORD_WIDTH-1:0] fCH_Hops,
  input  logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic [WORD_WIDTH-1:0] chosenCH,
  output logic [WORD_WIDTH-1:0] hopsfromCH,
  output logic [1:0]            dbg_state
);

  localparam int IW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam logic [WORD_WIDTH-1:0] NONE = '1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UPDATE = 2'd1, ST_SELECT = 2'd2} state_t;

  // Handshake: en_KCH is a one-cycle strobe accepted only in ST_IDLE; strobes
  // seen while the FSM is busy are dropped, HB_reset always wins and aborts.
  state_t                state_q, state_d;
  logic [MAX_CH-1:0]     valid_q, valid_d;
  logic [WORD_WIDTH-1:0] id_q   [MAX_CH];
  logic [WORD_WIDTH-1:0] id_d   [MAX_CH];
  logic [WORD_WIDTH-1:0] hops_q [MAX_CH];
  logic [WORD_WIDTH-1:0] hops_d [MAX_CH];
  logic [WORD_WIDTH-1:0] qv_q   [MAX_CH];
  logic [WORD_WIDTH-1:0] qv_d   [MAX_CH];
  logic [WORD_WIDTH-1:0] limit_q, limit_d;
  logic [WORD_WIDTH-1:0] cap_id_q, cap_id_d;
  logic [WORD_WIDTH-1:0] cap_hops_q, cap_hops_d;
  logic [WORD_WIDTH-1:0] cap_qv_q, cap_qv_d;
  logic [WORD_WIDTH-1:0] chosen_q, chosen_d;
  logic [WORD_WIDTH-1:0] hopsout_q, hopsout_d;

  logic [WORD_WIDTH-1:0] eff_limit, count;
  logic                  match_found, free_found, min_found, best_found;
  logic [IW-1:0]         match_idx, free_idx, min_idx, best_idx;
  logic [WORD_WIDTH-1:0] min_qv, best_qv, best_hops;

  // Table searches used by UPDATE (match/free/weakest) and SELECT (best).
  always_comb begin
    eff_limit   = (limit_q > WORD_WIDTH'(MAX_CH)) ? WORD_WIDTH'(MAX_CH) : limit_q;
    count       = '0;
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    min_found   = 1'b0;
    min_idx     = '0;
    min_qv      = '0;
    best_found  = 1'b0;
    best_idx    = '0;
    best_qv     = '0;
    best_hops   = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      count = count + WORD_WIDTH'(valid_q[i]);
      if (!match_found && valid_q[i] && id_q[i] == cap_id_q) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (valid_q[i] && (!min_found || qv_q[i] < min_qv)) begin
        min_found = 1'b1;
        min_idx   = IW'(i);
        min_qv    = qv_q[i];
      end
      if (valid_q[i] && (!best_found || qv_q[i] > best_qv ||
                         (qv_q[i] == best_qv && hops_q[i] < best_hops))) begin
        best_found = 1'b1;
        best_idx   = IW'(i);
        best_qv    = qv_q[i];
        best_hops  = hops_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    id_d       = id_q;
    hops_d     = hops_q;
    qv_d       = qv_q;
    limit_d    = limit_q;
    cap_id_d   = cap_id_q;
    cap_hops_d = cap_hops_q;
    cap_qv_d   = cap_qv_q;
    chosen_d   = chosen_q;
    hopsout_d  = hopsout_q;
    case (state_q)
      ST_IDLE: begin
        if (en_KCH && fCH_ID != NONE) begin
          cap_id_d   = fCH_ID;
          cap_hops_d = fCH_Hops;
          cap_qv_d   = fCH_QValue;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (match_found) begin
          hops_d[match_idx] = cap_hops_q;
          qv_d[match_idx]   = cap_qv_q;
        end else if (count < eff_limit && free_found) begin
          valid_d[free_idx] = 1'b1;
          id_d[free_idx]    = cap_id_q;
          hops_d[free_idx]  = cap_hops_q;
          qv_d[free_idx]    = cap_qv_q;
        end else if (min_found && cap_qv_q > min_qv) begin
          id_d[min_idx]   = cap_id_q;
          hops_d[min_idx] = cap_hops_q;
          qv_d[min_idx]   = cap_qv_q;
        end
        state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (best_found) begin
          chosen_d  = id_q[best_idx];
          hopsout_d = (best_hops == NONE) ? NONE : best_hops + 1'b1;
        end else begin
          chosen_d  = NONE;
          hopsout_d = NONE;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (HB_reset) begin
      valid_d   = '0;
      limit_d   = HB_CHlimit;
      chosen_d  = NONE;
      hopsout_d = NONE;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      limit_q   <= '0;
      chosen_q  <= NONE;
      hopsout_q <= NONE;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      limit_q   <= limit_d;
      chosen_q  <= chosen_d;
      hopsout_q <= hopsout_d;
    end
    // Payload storage is qualified by valid bits, so it needs no reset.
    id_q       <= id_d;
    hops_q     <= hops_d;
    qv_q       <= qv_d;
    cap_id_q   <= cap_id_d;
    cap_hops_q <= cap_hops_d;
    cap_qv_q   <= cap_qv_d;
  end

  assign chosenCH   = chosen_q;
  assign hopsfromCH = hopsout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_known_ch_table.sv
// Directed bench for known_ch_table: hand-computed CH selection scenarios.
module tb_known_ch_table;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        en_KCH = 1'b0;
  logic        HB_reset = 1'b0;
  logic [15:0] HB_CHlimit = '0;
  logic [15:0] fCH_ID = '0;
  logic [15:0] fCH_Hops = '0;
  logic [15:0] fCH_QValue = '0;
  logic [15:0] chosenCH;
  logic [15:0] hopsfromCH;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  known_ch_table dut (
    .clk(clk), .nrst(nrst), .en_KCH(en_KCH), .HB_reset(HB_reset),
    .HB_CHlimit(HB_CHlimit), .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops),
    .fCH_QValue(fCH_QValue), .chosenCH(chosenCH), .hopsfromCH(hopsfromCH),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic hb(input logic [15:0] lim);
    @(negedge clk);
    HB_reset = 1'b1; HB_CHlimit = lim;
    @(negedge clk);
    HB_reset = 1'b0;
  endtask

  // Returns one falling edge after the capture edge.
  task automatic adv(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q);
    @(negedge clk);
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = h; fCH_QValue = q;
    @(negedge clk);
    en_KCH = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL reset_chosen got %h want ffff", chosenCH); end
    checks++; if (hopsfromCH !== 16'hFFFF) begin errors++; $display("FAIL reset_hops got %h want ffff", hopsfromCH); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    // Limit register is zero out of reset, so an advert must be dropped.
    adv(16'h0005, 16'h0001, 16'h3000);
    settle();
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL reset_nolimit got %h want ffff", chosenCH); end
  endtask

  task automatic test_basic();
    hb(16'd3);
    adv(16'h0023, 16'h0002, 16'h3000);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL basic_update_state got %0d want 1", dbg_state); end
    @(negedge clk);
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL basic_latency got %h want ffff", chosenCH); end
    @(negedge clk);
    checks++; if (chosenCH !== 16'h0023) begin errors++; $display("FAIL basic_chosen got %h want 0023", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0003) begin errors++; $display("FAIL basic_hops got %h want 0003", hopsfromCH); end
  endtask

  task automatic test_tiebreak();
    adv(16'h0040, 16'h0001, 16'h3800); settle();
    checks++; if (chosenCH !== 16'h0040) begin errors++; $display("FAIL tie_better got %h want 0040", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0002) begin errors++; $display("FAIL tie_better_hops got %h want 0002", hopsfromCH); end
    adv(16'h0041, 16'h0001, 16'h3800); settle();
    checks++; if (chosenCH !== 16'h0040) begin errors++; $display("FAIL tie_index got %h want 0040", chosenCH); end
  endtask

  task automatic test_full_replace();
    adv(16'h0050, 16'h0000, 16'h2000); settle();
    checks++; if (chosenCH !== 16'h0040) begin errors++; $display("FAIL full_drop got %h want 0040", chosenCH); end
    adv(16'h0051, 16'h0004, 16'h3C00); settle();
    checks++; if (chosenCH !== 16'h0051) begin errors++; $display("FAIL full_replace got %h want 0051", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0005) begin errors++; $display("FAIL full_replace_hops got %h want 0005", hopsfromCH); end
  endtask

  task automatic test_update_in_place();
    adv(16'h0051, 16'h0004, 16'h1000); settle();
    checks++; if (chosenCH !== 16'h0040) begin errors++; $display("FAIL inplace_chosen got %h want 0040", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0002) begin errors++; $display("FAIL inplace_hops got %h want 0002", hopsfromCH); end
  endtask

  task automatic test_hb_priority();
    @(negedge clk);
    HB_reset = 1'b1; HB_CHlimit = 16'd3;
    en_KCH = 1'b1; fCH_ID = 16'h0060; fCH_Hops = 16'h0001; fCH_QValue = 16'h3FFF;
    @(negedge clk);
    HB_reset = 1'b0; en_KCH = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL hbprio_chosen got %h want ffff", chosenCH); end
    checks++; if (hopsfromCH !== 16'hFFFF) begin errors++; $display("FAIL hbprio_hops got %h want ffff", hopsfromCH); end
    hb(16'd0);
    adv(16'h0061, 16'h0001, 16'h0100); settle();
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL limit0_chosen got %h want ffff", chosenCH); end
    checks++; if (hopsfromCH !== 16'hFFFF) begin errors++; $display("FAIL limit0_hops got %h want ffff", hopsfromCH); end
  endtask

  task automatic test_clamp();
    hb(16'd20);
    // IDs 1..8 share one Q; hops 8..1, so the min-hops rule picks ID 8.
    for (int k = 1; k <= 8; k++) begin
      adv(16'(k), 16'(9 - k), 16'h1000);
      settle();
    end
    checks++; if (chosenCH !== 16'h0008) begin errors++; $display("FAIL clamp_hops_tie got %h want 0008", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0002) begin errors++; $display("FAIL clamp_hops_tie_hops got %h want 0002", hopsfromCH); end
    adv(16'h0009, 16'h0007, 16'h1100); settle();
    checks++; if (chosenCH !== 16'h0009) begin errors++; $display("FAIL clamp_replace got %h want 0009", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0008) begin errors++; $display("FAIL clamp_replace_hops got %h want 0008", hopsfromCH); end
  endtask

  task automatic test_saturate_invalid();
    hb(16'd1);
    adv(16'h0070, 16'hFFFF, 16'h0100); settle();
    checks++; if (chosenCH !== 16'h0070) begin errors++; $display("FAIL sat_chosen got %h want 0070", chosenCH); end
    checks++; if (hopsfromCH !== 16'hFFFF) begin errors++; $display("FAIL sat_hops got %h want ffff", hopsfromCH); end
    adv(16'hFFFF, 16'h0000, 16'h4000);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL invalid_state got %0d want 0", dbg_state); end
    settle();
    checks++; if (chosenCH !== 16'h0070) begin errors++; $display("FAIL invalid_id got %h want 0070", chosenCH); end
  endtask

  task automatic test_abort();
    hb(16'd2);
    adv(16'h0080, 16'h0000, 16'h0200);
    HB_reset = 1'b1; HB_CHlimit = 16'd2;
    @(negedge clk);
    HB_reset = 1'b0;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state got %0d want 0", dbg_state); end
    settle();
    checks++; if (chosenCH !== 16'hFFFF) begin errors++; $display("FAIL abort_chosen got %h want ffff", chosenCH); end
  endtask

  task automatic test_back_to_back();
    adv(16'h0090, 16'h0001, 16'h0500);
    // Second strobe lands while the FSM is in UPDATE and must be ignored.
    en_KCH = 1'b1; fCH_ID = 16'h0091; fCH_Hops = 16'h0000; fCH_QValue = 16'h0900;
    @(negedge clk);
    en_KCH = 1'b0;
    settle();
    checks++; if (chosenCH !== 16'h0090) begin errors++; $display("FAIL busy_chosen got %h want 0090", chosenCH); end
    checks++; if (hopsfromCH !== 16'h0002) begin errors++; $display("FAIL busy_hops got %h want 0002", hopsfromCH); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tiebreak();
    test_full_replace();
    test_update_in_place();
    test_hb_priority();
    test_clamp();
    test_saturate_invalid();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
